// File: rtl/trap_ctrl_pkg.sv
// rtl/trap_ctrl_pkg.sv - widths, CSR addresses, mstatus fields and FSM states for the trap sequencer
package trap_ctrl_pkg;

  localparam int XLEN  = 32;
  localparam int MXLEN = 32;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MSTATUS_MPP_LSB  = 11;

  typedef logic [4:0] trap_cause_t;

  localparam trap_cause_t IRQ_CODE_M_EXT = 5'd11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAVE_EPC,
    ST_SAVE_CAUSE,
    ST_SAVE_TVAL,
    ST_SAVE_STATUS,
    ST_RESTORE_STATUS,
    ST_REDIRECT
  } trap_ctrl_state_t;

  // mstatus as written on trap entry: stack MIE into MPIE, disable, land in M-mode
  function automatic logic [MXLEN-1:0] status_on_trap(input logic [MXLEN-1:0] ms);
    logic [MXLEN-1:0] r;
    r = ms;
    r[MSTATUS_MPIE_BIT]          = ms[MSTATUS_MIE_BIT];
    r[MSTATUS_MIE_BIT]           = 1'b0;
    r[MSTATUS_MPP_LSB +: 2]      = 2'b11;
    return r;
  endfunction

  // mstatus as written on MRET: pop MPIE into MIE, re-arm MPIE
  function automatic logic [MXLEN-1:0] status_on_mret(input logic [MXLEN-1:0] ms);
    logic [MXLEN-1:0] r;
    r = ms;
    r[MSTATUS_MIE_BIT]           = ms[MSTATUS_MPIE_BIT];
    r[MSTATUS_MPIE_BIT]          = 1'b1;
    r[MSTATUS_MPP_LSB +: 2]      = 2'b11;
    return r;
  endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// rtl/trap_ctrl_if.sv - request, CSR and PC-redirect signals between the pipeline and trap_ctrl
interface trap_ctrl_if;
  import trap_ctrl_pkg::*;

  logic              i_trap_req;
  trap_cause_t       i_trap_cause;
  logic [MXLEN-1:0]  i_trap_tval;
  logic [XLEN-1:0]   i_pc;
  logic              i_mret;
  logic              i_ext_irq;
  logic [MXLEN-1:0]  i_mstatus;
  logic [MXLEN-1:0]  i_mtvec;
  logic [MXLEN-1:0]  i_mepc;
  logic              o_csr_we;
  logic [11:0]       o_csr_addr;
  logic [MXLEN-1:0]  o_csr_wdata;
  logic              o_stall;
  logic              o_redirect;
  logic [XLEN-1:0]   o_redirect_pc;

  modport master (
    output i_trap_req, i_trap_cause, i_trap_tval, i_pc, i_mret, i_ext_irq,
           i_mstatus, i_mtvec, i_mepc,
    input  o_csr_we, o_csr_addr, o_csr_wdata, o_stall, o_redirect, o_redirect_pc
  );

  modport slave (
    input  i_trap_req, i_trap_cause, i_trap_tval, i_pc, i_mret, i_ext_irq,
           i_mstatus, i_mtvec, i_mepc,
    output o_csr_we, o_csr_addr, o_csr_wdata, o_stall, o_redirect, o_redirect_pc
  );
endinterface

// File: rtl/trap_ctrl_target_calc.sv
// rtl/trap_ctrl_target_calc.sv - redirect target from mtvec/mepc; vectored mode under COTM32_TRAP_VECTORED_EN
module trap_target_calc
  import trap_ctrl_pkg::*;
(
  input  logic [MXLEN-1:0] mtvec,
  input  logic [MXLEN-1:0] mepc,
  input  logic             is_mret,
  input  logic             is_irq,
  input  trap_cause_t      code,
  output logic [XLEN-1:0]  target
);

  logic [MXLEN-1:0] base;
  logic             unused_bits;

  assign base = {mtvec[MXLEN-1:2], 2'b00};

  // MRET returns to mepc; traps go to the mtvec base, offset per cause when vectored
  always_comb begin
    target = base;
    if (is_mret) begin
      target = {mepc[MXLEN-1:2], 2'b00};
    end
`ifdef COTM32_TRAP_VECTORED_EN
    else if (is_irq && (mtvec[1:0] == 2'b01)) begin
      target = base + MXLEN'({code, 2'b00});
    end
`endif
  end

`ifdef COTM32_TRAP_VECTORED_EN
  assign unused_bits = ^mepc[1:0];
`else
  assign unused_bits = ^{mtvec[1:0], mepc[1:0], is_irq, code};
`endif

endmodule

// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - machine-mode trap/MRET sequencer; optional COTM32_TRAP_VECTORED_EN enables vectored irq targets
module trap_ctrl
  import trap_ctrl_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  trap_ctrl_if.slave bus
);

  trap_ctrl_state_t state, state_nxt;

  logic             lat_irq;
  logic             lat_mret;
  trap_cause_t      lat_code;
  logic [MXLEN-1:0] lat_tval;
  logic [XLEN-1:0]  lat_pc;

  logic idle, irq_ok, take_trap, take_irq, take_mret, accept;
  logic [XLEN-1:0] target;

  // Reset gates acceptance so every output drops the moment reset asserts
  assign idle      = (state == ST_IDLE) && i_rst_n;
  assign irq_ok    = bus.i_ext_irq && bus.i_mstatus[MSTATUS_MIE_BIT];
  assign take_trap = idle && bus.i_trap_req;
  assign take_irq  = idle && !bus.i_trap_req && irq_ok;
  assign take_mret = idle && !bus.i_trap_req && !irq_ok && bus.i_mret;
  assign accept    = take_trap || take_irq || take_mret;

  trap_target_calc u_target (
    .mtvec   (bus.i_mtvec),
    .mepc    (bus.i_mepc),
    .is_mret (lat_mret),
    .is_irq  (lat_irq),
    .code    (lat_code),
    .target  (target)
  );

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Capture the accepted request so upstream may drop it once stalled
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lat_irq  <= 1'b0;
      lat_mret <= 1'b0;
      lat_code <= '0;
      lat_tval <= '0;
      lat_pc   <= '0;
    end else if (accept) begin
      lat_irq  <= take_irq;
      lat_mret <= take_mret;
      lat_code <= take_irq ? IRQ_CODE_M_EXT : bus.i_trap_cause;
      lat_tval <= take_irq ? '0 : bus.i_trap_tval;
      lat_pc   <= bus.i_pc;
    end
  end

  // Next state and per-state CSR write / redirect outputs
  always_comb begin
    state_nxt         = state;
    bus.o_csr_we      = 1'b0;
    bus.o_csr_addr    = '0;
    bus.o_csr_wdata   = '0;
    bus.o_stall       = (state != ST_IDLE) || accept;
    bus.o_redirect    = 1'b0;
    bus.o_redirect_pc = '0;
    case (state)
      ST_IDLE: begin
        if (take_trap || take_irq) state_nxt = ST_SAVE_EPC;
        else if (take_mret)        state_nxt = ST_RESTORE_STATUS;
      end
      ST_SAVE_EPC: begin
        bus.o_csr_we    = 1'b1;
        bus.o_csr_addr  = CSR_MEPC;
        bus.o_csr_wdata = MXLEN'(lat_pc);
        state_nxt       = ST_SAVE_CAUSE;
      end
      ST_SAVE_CAUSE: begin
        bus.o_csr_we    = 1'b1;
        bus.o_csr_addr  = CSR_MCAUSE;
        bus.o_csr_wdata = {lat_irq, {(MXLEN-6){1'b0}}, lat_code};
        state_nxt       = ST_SAVE_TVAL;
      end
      ST_SAVE_TVAL: begin
        bus.o_csr_we    = 1'b1;
        bus.o_csr_addr  = CSR_MTVAL;
        bus.o_csr_wdata = lat_tval;
        state_nxt       = ST_SAVE_STATUS;
      end
      ST_SAVE_STATUS: begin
        bus.o_csr_we    = 1'b1;
        bus.o_csr_addr  = CSR_MSTATUS;
        bus.o_csr_wdata = status_on_trap(bus.i_mstatus);
        state_nxt       = ST_REDIRECT;
      end
      ST_RESTORE_STATUS: begin
        bus.o_csr_we    = 1'b1;
        bus.o_csr_addr  = CSR_MSTATUS;
        bus.o_csr_wdata = status_on_mret(bus.i_mstatus);
        state_nxt       = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        bus.o_redirect    = 1'b1;
        bus.o_redirect_pc = target;
        state_nxt         = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb/tb_trap_ctrl.sv - scoreboard bench for trap_ctrl: CSR write and redirect ordering, latency, priority, reset abort
module tb_trap_ctrl;
  import trap_ctrl_pkg::*;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
  } wr_t;

`ifdef COTM32_TRAP_VECTORED_EN
  localparam logic [31:0] IRQ_TARGET = 32'h8000_002C;
`else
  localparam logic [31:0] IRQ_TARGET = 32'h8000_0000;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  trap_ctrl_if bus ();

  trap_ctrl dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  logic [31:0] csr_mstatus, csr_mtvec, csr_mepc;
  logic        poke_en;
  logic [11:0] poke_addr;
  logic [31:0] poke_data;

  assign bus.i_mstatus = csr_mstatus;
  assign bus.i_mtvec   = csr_mtvec;
  assign bus.i_mepc    = csr_mepc;

  wr_t         exp_wr[$];
  logic [31:0] exp_rd[$];
  wr_t         mon_e;
  logic [31:0] mon_pc;
  int total = 0;
  int bad   = 0;

  // CSR file model: bench pokes take precedence, otherwise commit DUT writes
  always @(posedge clk) begin
    if (poke_en) begin
      case (poke_addr)
        CSR_MSTATUS: csr_mstatus <= poke_data;
        CSR_MTVEC:   csr_mtvec   <= poke_data;
        CSR_MEPC:    csr_mepc    <= poke_data;
        default: ;
      endcase
    end else if (bus.o_csr_we) begin
      case (bus.o_csr_addr)
        CSR_MSTATUS: csr_mstatus <= bus.o_csr_wdata;
        CSR_MTVEC:   csr_mtvec   <= bus.o_csr_wdata;
        CSR_MEPC:    csr_mepc    <= bus.o_csr_wdata;
        default: ;
      endcase
    end
  end

  // Scoreboard: every CSR write and redirect pulse must match the next expectation
  always @(negedge clk) begin
    if (bus.o_csr_we === 1'b1) begin
      total++;
      if (exp_wr.size() == 0) begin
        bad++;
        $display("FAIL csr_write: got addr=%h data=%h, required no write", bus.o_csr_addr, bus.o_csr_wdata);
      end else begin
        mon_e = exp_wr.pop_front();
        if (bus.o_csr_addr !== mon_e.addr || bus.o_csr_wdata !== mon_e.data) begin
          bad++;
          $display("FAIL csr_write: got addr=%h data=%h, required addr=%h data=%h",
                   bus.o_csr_addr, bus.o_csr_wdata, mon_e.addr, mon_e.data);
        end
      end
    end
    if (bus.o_redirect === 1'b1) begin
      total++;
      if (exp_rd.size() == 0) begin
        bad++;
        $display("FAIL redirect: got pc=%h, required no redirect", bus.o_redirect_pc);
      end else begin
        mon_pc = exp_rd.pop_front();
        if (bus.o_redirect_pc !== mon_pc) begin
          bad++;
          $display("FAIL redirect: got pc=%h, required pc=%h", bus.o_redirect_pc, mon_pc);
        end
      end
    end
  end

  task automatic poke(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    @(posedge clk);
    #1 poke_en = 1'b0;
  endtask

  task automatic push_wr(input logic [11:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a; e.data = d;
    exp_wr.push_back(e);
  endtask

  // Request already driven at a negedge; returns stall-at-accept and cycles to redirect
  task automatic launch_and_wait(output int cyc, output logic acc);
    #1 acc = bus.o_stall;
    @(posedge clk);
    #1 bus.i_trap_req = 1'b0; bus.i_mret = 1'b0;
    cyc = 0;
    while (cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (bus.o_redirect === 1'b1) break;
    end
  endtask

  task automatic test_reset;
    logic [79:0] outs;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 outs = {bus.o_csr_we, bus.o_csr_addr, bus.o_csr_wdata, bus.o_stall, bus.o_redirect, bus.o_redirect_pc};
    total++;
    if (outs !== 80'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %h, required 0", outs);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_illegal_inst;
    int cyc; logic acc;
    poke(CSR_MTVEC, 32'h8000_0000);
    poke(CSR_MSTATUS, 32'h0000_0008);
    push_wr(CSR_MEPC, 32'h100);
    push_wr(CSR_MCAUSE, 32'h2);
    push_wr(CSR_MTVAL, 32'h13);
    push_wr(CSR_MSTATUS, 32'h0000_1880);
    exp_rd.push_back(32'h8000_0000);
    @(negedge clk);
    bus.i_trap_req = 1'b1; bus.i_trap_cause = 5'd2; bus.i_trap_tval = 32'h13; bus.i_pc = 32'h100;
    launch_and_wait(cyc, acc);
    total++;
    if (acc !== 1'b1) begin bad++; $display("FAIL trap_accept_stall: got %b, required 1", acc); end
    total++;
    if (cyc != 5) begin bad++; $display("FAIL trap_latency: got %0d, required 5", cyc); end
    @(posedge clk); #1;
    total++;
    if (csr_mstatus !== 32'h0000_1880 || csr_mepc !== 32'h100) begin
      bad++;
      $display("FAIL trap_csr_state: got mstatus=%h mepc=%h, required 00001880 00000100", csr_mstatus, csr_mepc);
    end
  endtask

  task automatic test_mret;
    int cyc; logic acc;
    poke(CSR_MEPC, 32'h204);
    push_wr(CSR_MSTATUS, 32'h0000_1888);
    exp_rd.push_back(32'h204);
    @(negedge clk);
    bus.i_mret = 1'b1;
    launch_and_wait(cyc, acc);
    total++;
    if (acc !== 1'b1) begin bad++; $display("FAIL mret_accept_stall: got %b, required 1", acc); end
    total++;
    if (cyc != 2) begin bad++; $display("FAIL mret_latency: got %0d, required 2", cyc); end
  endtask

  task automatic test_irq;
    int cyc; logic acc;
    poke(CSR_MTVEC, 32'h8000_0001);
    poke(CSR_MSTATUS, 32'h0000_1888);
    push_wr(CSR_MEPC, 32'h400);
    push_wr(CSR_MCAUSE, 32'h8000_000B);
    push_wr(CSR_MTVAL, 32'h0);
    push_wr(CSR_MSTATUS, 32'h0000_1880);
    exp_rd.push_back(IRQ_TARGET);
    @(negedge clk);
    bus.i_ext_irq = 1'b1; bus.i_pc = 32'h400; bus.i_trap_tval = 32'hDEAD_BEEF; bus.i_trap_cause = 5'd4;
    launch_and_wait(cyc, acc);
    total++;
    if (cyc != 5) begin bad++; $display("FAIL irq_latency: got %0d, required 5", cyc); end
    @(negedge clk);
    #1;
    total++;
    if (bus.o_stall !== 1'b0) begin bad++; $display("FAIL irq_no_retake: got stall=%b, required 0", bus.o_stall); end
    bus.i_ext_irq = 1'b0;
  endtask

  task automatic test_trap_and_irq;
    int cyc; logic acc;
    poke(CSR_MTVEC, 32'h8000_0000);
    poke(CSR_MSTATUS, 32'h0000_0008);
    push_wr(CSR_MEPC, 32'h300);
    push_wr(CSR_MCAUSE, 32'h3);
    push_wr(CSR_MTVAL, 32'h55);
    push_wr(CSR_MSTATUS, 32'h0000_1880);
    exp_rd.push_back(32'h8000_0000);
    @(negedge clk);
    bus.i_trap_req = 1'b1; bus.i_ext_irq = 1'b1;
    bus.i_trap_cause = 5'd3; bus.i_trap_tval = 32'h55; bus.i_pc = 32'h300;
    launch_and_wait(cyc, acc);
    total++;
    if (cyc != 5) begin bad++; $display("FAIL both_latency: got %0d, required 5", cyc); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      total++;
      if (bus.o_stall !== 1'b0) begin bad++; $display("FAIL both_irq_pending: got stall=%b, required 0", bus.o_stall); end
    end
    bus.i_ext_irq = 1'b0;
  endtask

  task automatic test_irq_masked;
    poke(CSR_MSTATUS, 32'h0);
    @(negedge clk);
    bus.i_ext_irq = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (bus.o_stall !== 1'b0 || bus.o_csr_we !== 1'b0) begin
        bad++;
        $display("FAIL masked_irq: got stall=%b we=%b, required 0 0", bus.o_stall, bus.o_csr_we);
      end
      @(negedge clk);
    end
    bus.i_ext_irq = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [79:0] outs;
    poke(CSR_MTVEC, 32'h8000_0000);
    poke(CSR_MSTATUS, 32'h0000_0008);
    push_wr(CSR_MEPC, 32'h500);
    push_wr(CSR_MCAUSE, 32'h7);
    @(negedge clk);
    bus.i_trap_req = 1'b1; bus.i_trap_cause = 5'd7; bus.i_trap_tval = 32'h9; bus.i_pc = 32'h500;
    @(posedge clk);
    #1 bus.i_trap_req = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (bus.o_csr_addr !== CSR_MCAUSE) begin
      bad++;
      $display("FAIL mid_in_save_cause: got addr=%h, required %h", bus.o_csr_addr, CSR_MCAUSE);
    end
    rst_n = 1'b0;
    #1 outs = {bus.o_csr_we, bus.o_csr_addr, bus.o_csr_wdata, bus.o_stall, bus.o_redirect, bus.o_redirect_pc};
    total++;
    if (outs !== 80'd0) begin bad++; $display("FAIL mid_reset_outputs: got %h, required 0", outs); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      total++;
      if (bus.o_redirect !== 1'b0 || bus.o_csr_we !== 1'b0 || bus.o_stall !== 1'b0) begin
        bad++;
        $display("FAIL mid_after_release: got redirect=%b we=%b stall=%b, required 0 0 0",
                 bus.o_redirect, bus.o_csr_we, bus.o_stall);
      end
    end
    total++;
    if (csr_mstatus !== 32'h0000_0008) begin
      bad++;
      $display("FAIL mid_no_status_write: got mstatus=%h, required 00000008", csr_mstatus);
    end
  endtask

  initial begin
    poke_en = 1'b0; poke_addr = '0; poke_data = '0;
    bus.i_trap_req = 1'b0; bus.i_trap_cause = '0; bus.i_trap_tval = '0;
    bus.i_pc = '0; bus.i_mret = 1'b0; bus.i_ext_irq = 1'b0;
    test_reset();
    test_illegal_inst();
    test_mret();
    test_irq();
    test_trap_and_irq();
    test_irq_masked();
    test_reset_mid();
    total++;
    if (exp_wr.size() != 0 || exp_rd.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d writes %0d redirects left, required 0 0", exp_wr.size(), exp_rd.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
